// File: rtl/mem_tg_pkg.sv
// Shared types and helpers for the memory traffic generator.
package mem_tg_pkg;

   // Run-level FSM encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_GAP   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } mtg_state_e;

   // DRAM-select modes
   localparam logic [1:0] MODE_SRAM = 2'd0;
   localparam logic [1:0] MODE_DRAM = 2'd1;
   localparam logic [1:0] MODE_ALT  = 2'd2;
   localparam logic [1:0] MODE_LFSR = 2'd3;

   // Fibonacci LFSR step, taps x^16 + x^14 + x^13 + x^11 (right-shifting form)
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   // Clamp a 32-bit cycle delta into the 16-bit latency range
   function automatic logic [15:0] sat16(input logic [31:0] v);
      return (v[31:16] != 16'd0) ? 16'hFFFF : v[15:0];
   endfunction

endpackage

// File: rtl/mem_tg_ts_fifo.sv
// Issue-timestamp FIFO. The parent never pushes more than DEPTH entries or
// pops an empty FIFO, so there is no full/empty tracking here.
module mem_tg_ts_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign rd_data = mem_q[rd_ptr_q];

   // Pointer advance on push/pop
   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   // Pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage, no reset needed: entries are only read after being written
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/memory_traffic_generator.sv
// Memory traffic generator: issues a programmed burst of requests to a
// latency injector, caps requests in flight, and gathers per-run stats.
module memory_traffic_generator
   import mem_tg_pkg::*;
#(
   parameter int          SIZE_WIDTH      = 16,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [15:0]           cfg_num_reqs,
   input  logic [SIZE_WIDTH-1:0] cfg_size_bytes,
   input  logic [1:0]            cfg_dram_mode,
   input  logic [7:0]            cfg_issue_gap,
   output logic                  req_valid,
   output logic                  req_is_dram,
   output logic [SIZE_WIDTH-1:0] req_size_bytes,
   input  logic                  req_ready,
   input  logic                  resp_valid,
   input  logic [SIZE_WIDTH-1:0] resp_size_bytes,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           issued_count,
   output logic [15:0]           completed_count,
   output logic [4:0]            outstanding,
   output logic [15:0]           lat_min,
   output logic [15:0]           lat_max,
   output logic [31:0]           lat_sum,
   output logic [31:0]           bytes_completed,
   output logic                  resp_error
);

   mtg_state_e            state_q, state_d;
   logic [15:0]           num_reqs_q, num_reqs_d;
   logic [SIZE_WIDTH-1:0] size_q, size_d;
   logic [1:0]            mode_q, mode_d;
   logic [7:0]            gap_q, gap_d;
   logic [7:0]            gap_cnt_q, gap_cnt_d;
   logic [15:0]           issued_q, issued_d;
   logic [15:0]           completed_q, completed_d;
   logic [4:0]            outstanding_q, outstanding_d;
   logic [15:0]           lat_min_q, lat_min_d;
   logic [15:0]           lat_max_q, lat_max_d;
   logic [31:0]           lat_sum_q, lat_sum_d;
   logic [31:0]           bytes_q, bytes_d;
   logic                  resp_error_q, resp_error_d;
   logic                  alt_q, alt_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic [31:0]           cyc_q, cyc_d;
   logic                  req_valid_q, req_valid_d;
   logic                  req_is_dram_q, req_is_dram_d;
   logic [SIZE_WIDTH-1:0] req_size_q, req_size_d;

   logic        accept, resp_ok, start_fire;
   logic [31:0] ts_head;
   logic [15:0] lat16;

   // req_valid_q only rises in ISSUE, so accept implies ISSUE
   assign accept     = req_valid_q & req_ready;
   assign resp_ok    = resp_valid & (outstanding_q != 5'd0);
   assign start_fire = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign lat16      = sat16(cyc_q - ts_head);

   mem_tg_ts_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (32)
   ) u_ts_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (accept),
      .pop     (resp_ok),
      .wr_data (cyc_q),
      .rd_data (ts_head)
   );

   // Next-state: run FSM, counters, response stats and request payload
   always_comb begin
      state_d       = state_q;
      num_reqs_d    = num_reqs_q;
      size_d        = size_q;
      mode_d        = mode_q;
      gap_d         = gap_q;
      gap_cnt_d     = gap_cnt_q;
      issued_d      = issued_q;
      completed_d   = completed_q;
      outstanding_d = outstanding_q;
      lat_min_d     = lat_min_q;
      lat_max_d     = lat_max_q;
      lat_sum_d     = lat_sum_q;
      bytes_d       = bytes_q;
      alt_d         = alt_q;
      lfsr_d        = lfsr_q;
      cyc_d         = cyc_q + 32'd1;
      // a stray response is flagged even in the cycle a new run starts
      resp_error_d  = resp_error_q | (resp_valid & ~resp_ok);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_fire) begin
               state_d      = (cfg_num_reqs == 16'd0) ? ST_DONE : ST_ISSUE;
               num_reqs_d   = cfg_num_reqs;
               size_d       = cfg_size_bytes;
               mode_d       = cfg_dram_mode;
               gap_d        = cfg_issue_gap;
               issued_d     = '0;
               completed_d  = '0;
               lat_min_d    = 16'hFFFF;
               lat_max_d    = '0;
               lat_sum_d    = '0;
               bytes_d      = '0;
               alt_d        = 1'b0;
               resp_error_d = resp_valid & ~resp_ok;
            end
         end
         ST_ISSUE: begin
            if (accept) begin
               if (issued_q + 16'd1 == num_reqs_q) begin
                  state_d = ST_DRAIN;
               end else if (gap_q != 8'd0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = gap_q;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 8'd1) state_d = ST_ISSUE;
            else                   gap_cnt_d = gap_cnt_q - 8'd1;
         end
         ST_DRAIN: begin
            if (completed_q == num_reqs_q) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         issued_d = issued_q + 16'd1;
         alt_d    = ~alt_q;
         lfsr_d   = lfsr_next(lfsr_q);
      end

      if (resp_ok) begin
         completed_d = completed_q + 16'd1;
         lat_min_d   = (lat16 < lat_min_q) ? lat16 : lat_min_q;
         lat_max_d   = (lat16 > lat_max_q) ? lat16 : lat_max_q;
         lat_sum_d   = lat_sum_q + {16'd0, lat16};
         bytes_d     = bytes_q + 32'(resp_size_bytes);
      end

      case ({accept, resp_ok})
         2'b10:   outstanding_d = outstanding_q + 5'd1;
         2'b01:   outstanding_d = outstanding_q - 5'd1;
         default: outstanding_d = outstanding_q;
      endcase

      // Payload follows next-cycle config/selector state; those only move on
      // start or accept, so a stalled request keeps a stable payload.
      req_valid_d = (state_d == ST_ISSUE) && (outstanding_d < 5'(MAX_OUTSTANDING));
      req_size_d  = size_d;
      case (mode_d)
         MODE_SRAM: req_is_dram_d = 1'b0;
         MODE_DRAM: req_is_dram_d = 1'b1;
         MODE_ALT:  req_is_dram_d = alt_d;
         default:   req_is_dram_d = lfsr_d[0];
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         num_reqs_q    <= '0;
         size_q        <= '0;
         mode_q        <= MODE_SRAM;
         gap_q         <= '0;
         gap_cnt_q     <= '0;
         issued_q      <= '0;
         completed_q   <= '0;
         outstanding_q <= '0;
         lat_min_q     <= 16'hFFFF;
         lat_max_q     <= '0;
         lat_sum_q     <= '0;
         bytes_q       <= '0;
         resp_error_q  <= 1'b0;
         alt_q         <= 1'b0;
         lfsr_q        <= LFSR_SEED;
         cyc_q         <= '0;
         req_valid_q   <= 1'b0;
         req_is_dram_q <= 1'b0;
         req_size_q    <= '0;
      end else begin
         state_q       <= state_d;
         num_reqs_q    <= num_reqs_d;
         size_q        <= size_d;
         mode_q        <= mode_d;
         gap_q         <= gap_d;
         gap_cnt_q     <= gap_cnt_d;
         issued_q      <= issued_d;
         completed_q   <= completed_d;
         outstanding_q <= outstanding_d;
         lat_min_q     <= lat_min_d;
         lat_max_q     <= lat_max_d;
         lat_sum_q     <= lat_sum_d;
         bytes_q       <= bytes_d;
         resp_error_q  <= resp_error_d;
         alt_q         <= alt_d;
         lfsr_q        <= lfsr_d;
         cyc_q         <= cyc_d;
         req_valid_q   <= req_valid_d;
         req_is_dram_q <= req_is_dram_d;
         req_size_q    <= req_size_d;
      end
   end

   assign req_valid       = req_valid_q;
   assign req_is_dram     = req_is_dram_q;
   assign req_size_bytes  = req_size_q;
   assign busy            = (state_q == ST_ISSUE) | (state_q == ST_GAP) | (state_q == ST_DRAIN);
   assign done            = (state_q == ST_DONE);
   assign issued_count    = issued_q;
   assign completed_count = completed_q;
   assign outstanding     = outstanding_q;
   assign lat_min         = lat_min_q;
   assign lat_max         = lat_max_q;
   assign lat_sum         = lat_sum_q;
   assign bytes_completed = bytes_q;
   assign resp_error      = resp_error_q;

endmodule

// File: tb/tb_memory_traffic_generator.sv
// Directed bench: table of whole runs against a fixed-latency responder,
// plus hand sequences for backpressure, stray responses and mid-run reset.
module tb_memory_traffic_generator;

   localparam int SW = 16;
   localparam int MO = 4;

   logic          clk             = 1'b0;
   logic          reset           = 1'b1;
   logic          start           = 1'b0;
   logic [15:0]   cfg_num_reqs    = '0;
   logic [SW-1:0] cfg_size_bytes  = '0;
   logic [1:0]    cfg_dram_mode   = '0;
   logic [7:0]    cfg_issue_gap   = '0;
   logic          req_ready       = 1'b0;
   logic          resp_valid      = 1'b0;
   logic [SW-1:0] resp_size_bytes = '0;
   logic          req_valid, req_is_dram, busy, done, resp_error;
   logic [SW-1:0] req_size_bytes;
   logic [15:0]   issued_count, completed_count, lat_min, lat_max;
   logic [4:0]    outstanding;
   logic [31:0]   lat_sum, bytes_completed;

   initial forever #5 clk = ~clk;

   memory_traffic_generator #(
      .SIZE_WIDTH      (SW),
      .MAX_OUTSTANDING (MO),
      .LFSR_SEED       (16'hACE1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .cfg_num_reqs    (cfg_num_reqs),
      .cfg_size_bytes  (cfg_size_bytes),
      .cfg_dram_mode   (cfg_dram_mode),
      .cfg_issue_gap   (cfg_issue_gap),
      .req_valid       (req_valid),
      .req_is_dram     (req_is_dram),
      .req_size_bytes  (req_size_bytes),
      .req_ready       (req_ready),
      .resp_valid      (resp_valid),
      .resp_size_bytes (resp_size_bytes),
      .busy            (busy),
      .done            (done),
      .issued_count    (issued_count),
      .completed_count (completed_count),
      .outstanding     (outstanding),
      .lat_min         (lat_min),
      .lat_max         (lat_max),
      .lat_sum         (lat_sum),
      .bytes_completed (bytes_completed),
      .resp_error      (resp_error)
   );

   typedef struct {
      logic [15:0]   num;
      logic [SW-1:0] size;
      logic [1:0]    mode;
      logic [7:0]    gap;
      int            lat;
      logic [15:0]   e_lmin;
      logic [15:0]   e_lmax;
      logic [31:0]   e_sum;
      logic [31:0]   e_bytes;
      int            e_maxout;
      logic [15:0]   e_pat;   // req_is_dram of each accept, bit i = i-th accept
      int            e_spc;   // cycles between consecutive accepts, 0 = don't care
   } run_t;

   typedef struct {
      int            due;
      logic [SW-1:0] sz;
   } pend_t;

   // main -> responder requests (main-owned)
   int flush_req = 0;
   int inj_req   = 0;
   int hold_req  = 0;
   int hold_len  = 0;
   int lat       = 2;

   // responder-owned observations
   pend_t pend[$];
   int    acc_k[$];
   logic  acc_d[$];
   int    max_out, stall_cnt, hold_viol, full_viol;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   // Fixed-latency in-order responder and request monitor, on the falling edge
   initial begin : responder
      int k, last_due, hold_left, flush_ack, inj_ack, hold_ack, due;
      logic pv, pr, pd;
      logic [SW-1:0] ps;
      k = 0; last_due = 0; hold_left = 0; flush_ack = 0; inj_ack = 0; hold_ack = 0;
      pv = 1'b0; pr = 1'b0; pd = 1'b0; ps = '0;
      max_out = 0; stall_cnt = 0; hold_viol = 0; full_viol = 0;
      forever begin
         @(negedge clk);
         k++;
         if (flush_req != flush_ack) begin
            flush_ack = flush_req;
            pend.delete(); acc_k.delete(); acc_d.delete();
            max_out = 0; stall_cnt = 0; hold_viol = 0; full_viol = 0;
            last_due = 0; pv = 1'b0;
         end
         if (hold_req != hold_ack) begin
            hold_ack  = hold_req;
            hold_left = hold_len;
         end
         if (pv && !pr && (!req_valid || req_is_dram !== pd || req_size_bytes !== ps))
            hold_viol++;
         if (req_valid && outstanding >= 5'(MO)) full_viol++;
         if (int'(outstanding) > max_out) max_out = int'(outstanding);
         if (hold_left > 0) begin
            req_ready = 1'b0;
            hold_left--;
         end else begin
            req_ready = 1'b1;
         end
         resp_valid = 1'b0;
         resp_size_bytes = '0;
         if (pend.size() > 0 && pend[0].due == k) begin
            resp_valid = 1'b1;
            resp_size_bytes = pend[0].sz;
            void'(pend.pop_front());
         end
         if (inj_req != inj_ack) begin
            inj_ack = inj_req;
            resp_valid = 1'b1;
            resp_size_bytes = SW'(7);
         end
         if (req_valid && req_ready) begin
            due = k + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{due, req_size_bytes});
            acc_k.push_back(k);
            acc_d.push_back(req_is_dram);
         end else if (req_valid) begin
            stall_cnt++;
         end
         pv = req_valid; pr = req_ready; pd = req_is_dram; ps = req_size_bytes;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      flush_req++;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic do_start(input logic [15:0] n, input logic [SW-1:0] sz,
                           input logic [1:0] m, input logic [7:0] g);
      cfg_num_reqs   = n;
      cfg_size_bytes = sz;
      cfg_dram_mode  = m;
      cfg_issue_gap  = g;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!done && n < 3000) begin
         tick();
         n++;
      end
      chk({nm, "_done"}, 32'(done), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_req_valid"}, 32'(req_valid), 32'd0);
      chk({nm, "_req_is_dram"}, 32'(req_is_dram), 32'd0);
      chk({nm, "_req_size"}, 32'(req_size_bytes), 32'd0);
      chk({nm, "_busy"}, 32'(busy), 32'd0);
      chk({nm, "_done"}, 32'(done), 32'd0);
      chk({nm, "_issued"}, 32'(issued_count), 32'd0);
      chk({nm, "_completed"}, 32'(completed_count), 32'd0);
      chk({nm, "_outstanding"}, 32'(outstanding), 32'd0);
      chk({nm, "_lat_min"}, 32'(lat_min), 32'h0000FFFF);
      chk({nm, "_lat_max"}, 32'(lat_max), 32'd0);
      chk({nm, "_lat_sum"}, lat_sum, 32'd0);
      chk({nm, "_bytes"}, bytes_completed, 32'd0);
      chk({nm, "_resp_error"}, 32'(resp_error), 32'd0);
   endtask

   run_t tbl[6];

   initial begin : main
      run_t r;
      logic [15:0] pat;
      int bad, n;

      //            num     size    mode   gap   lat  lmin      lmax      sum     bytes    mo  pat       spc
      tbl[0] = '{16'd4,  16'd64,  2'd0, 8'd0, 2,  16'd2,    16'd2,    32'd8,   32'd256, 2, 16'h0000, 1};
      tbl[1] = '{16'd10, 16'd32,  2'd1, 8'd0, 30, 16'd30,   16'd30,   32'd300, 32'd320, 4, 16'h03FF, 0};
      tbl[2] = '{16'd4,  16'd16,  2'd2, 8'd3, 2,  16'd2,    16'd2,    32'd8,   32'd64,  1, 16'h000A, 4};
      tbl[3] = '{16'd4,  16'd8,   2'd3, 8'd1, 5,  16'd5,    16'd5,    32'd20,  32'd32,  3, 16'h0001, 2};
      tbl[4] = '{16'd0,  16'd5,   2'd1, 8'd0, 2,  16'hFFFF, 16'd0,    32'd0,   32'd0,   0, 16'h0000, 0};
      tbl[5] = '{16'd6,  16'd100, 2'd1, 8'd0, 1,  16'd1,    16'd1,    32'd6,   32'd600, 1, 16'h003F, 1};

      // reset state
      do_reset();
      chk_reset_outputs("reset");

      // whole-run table
      for (int i = 0; i < 6; i++) begin
         r = tbl[i];
         do_reset();
         lat = r.lat;
         do_start(r.num, r.size, r.mode, r.gap);
         wait_done($sformatf("row%0d", i));
         chk($sformatf("row%0d_busy", i), 32'(busy), 32'd0);
         chk($sformatf("row%0d_issued", i), 32'(issued_count), 32'(r.num));
         chk($sformatf("row%0d_completed", i), 32'(completed_count), 32'(r.num));
         chk($sformatf("row%0d_accepts", i), 32'(acc_k.size()), 32'(r.num));
         chk($sformatf("row%0d_outstanding", i), 32'(outstanding), 32'd0);
         chk($sformatf("row%0d_lat_min", i), 32'(lat_min), 32'(r.e_lmin));
         chk($sformatf("row%0d_lat_max", i), 32'(lat_max), 32'(r.e_lmax));
         chk($sformatf("row%0d_lat_sum", i), lat_sum, r.e_sum);
         chk($sformatf("row%0d_bytes", i), bytes_completed, r.e_bytes);
         chk($sformatf("row%0d_max_out", i), 32'(max_out), 32'(r.e_maxout));
         chk($sformatf("row%0d_valid_at_full", i), 32'(full_viol), 32'd0);
         chk($sformatf("row%0d_resp_error", i), 32'(resp_error), 32'd0);
         pat = '0;
         for (int j = 0; j < acc_d.size() && j < 16; j++) pat[j] = acc_d[j];
         chk($sformatf("row%0d_dram_seq", i), 32'(pat), 32'(r.e_pat));
         if (r.e_spc != 0) begin
            bad = 0;
            for (int j = 1; j < acc_k.size(); j++)
               if (acc_k[j] - acc_k[j-1] != r.e_spc) bad++;
            chk($sformatf("row%0d_spacing", i), 32'(bad), 32'd0);
         end
      end

      // ready held low for 5 cycles while valid
      do_reset();
      lat = 3;
      hold_len = 6;
      hold_req++;
      do_start(16'd1, 16'h1234, 2'd1, 8'd0);
      wait_done("hold");
      chk("hold_stall_cycles", 32'(stall_cnt), 32'd5);
      chk("hold_payload_stable", 32'(hold_viol), 32'd0);
      chk("hold_accepts", 32'(acc_k.size()), 32'd1);
      chk("hold_issued", 32'(issued_count), 32'd1);
      chk("hold_lat_min", 32'(lat_min), 32'd3);
      chk("hold_bytes", bytes_completed, 32'h00001234);

      // stray response while idle, cleared by the next start
      do_reset();
      inj_req++;
      tick();
      tick();
      chk("idle_resp_error", 32'(resp_error), 32'd1);
      chk("idle_completed", 32'(completed_count), 32'd0);
      chk("idle_outstanding", 32'(outstanding), 32'd0);
      lat = 2;
      do_start(16'd1, 16'd9, 2'd0, 8'd0);
      chk("idle_err_cleared", 32'(resp_error), 32'd0);
      chk("idle_busy", 32'(busy), 32'd1);
      wait_done("idle_run");
      chk("idle_run_completed", 32'(completed_count), 32'd1);
      chk("idle_run_error", 32'(resp_error), 32'd0);

      // reset with 3 requests in flight, then late responses
      do_reset();
      lat = 30;
      do_start(16'd10, 16'd32, 2'd1, 8'd0);
      n = 0;
      while (outstanding != 5'd3 && n < 50) begin
         tick();
         n++;
      end
      chk("mid_outstanding3", 32'(outstanding), 32'd3);
      reset = 1'b1;
      tick();
      chk_reset_outputs("mid_reset");
      reset = 1'b0;
      repeat (40) tick();
      chk("late_resp_error", 32'(resp_error), 32'd1);
      chk("late_completed", 32'(completed_count), 32'd0);
      chk("late_outstanding", 32'(outstanding), 32'd0);
      chk("late_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
